// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port priority, starvation-bounded fetch.
// Fixed IDLE -> ACCESS -> RESP cadence, one access per three cycles.
module mem_arbiter #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_DEPTH  = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_DONE,
  output logic [WORD_W-1:0] IF_RDATA,
  output logic              IF_ERR,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [WORD_W-1:0] D_WDATA,
  output logic              D_DONE,
  output logic [WORD_W-1:0] D_RDATA,
  output logic              D_ERR,
  output logic              MEM_ON,
  output logic              MEM_W,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0] MEM_DIN,
  input  logic [WORD_W-1:0] MEM_DOUT,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              win_d;
  logic              err;
  logic              is_wr;
  logic [CNT_W-1:0]  cnt;
  logic              pick_d;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    pick_d   = D_REQ && !(IF_REQ && cnt == CNT_MAX);
    sel_addr = pick_d ? D_ADDR : IF_ADDR;
    sel_oor  = {1'b0, sel_addr} >= DEPTH;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      win_d    <= 1'b0;
      err      <= 1'b0;
      is_wr    <= 1'b0;
      cnt      <= '0;
      MEM_ON   <= 1'b0;
      MEM_W    <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DIN  <= '0;
      BUSY     <= 1'b0;
      IF_DONE  <= 1'b0;
      IF_ERR   <= 1'b0;
      IF_RDATA <= '0;
      D_DONE   <= 1'b0;
      D_ERR    <= 1'b0;
      D_RDATA  <= '0;
    end else begin
      IF_DONE <= 1'b0;
      IF_ERR  <= 1'b0;
      D_DONE  <= 1'b0;
      D_ERR   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (IF_REQ || D_REQ) begin
            state    <= ACCESS;
            BUSY     <= 1'b1;
            win_d    <= pick_d;
            err      <= sel_oor;
            is_wr    <= pick_d && D_WE;
            MEM_ON   <= !sel_oor;
            MEM_W    <= !sel_oor && pick_d && D_WE;
            MEM_ADDR <= sel_addr;
            MEM_DIN  <= pick_d ? D_WDATA : '0;
            // only D grants that bypass a waiting fetch count
            cnt <= (pick_d && IF_REQ) ? cnt + 1'b1 : '0;
          end
        end
        ACCESS: begin
          state  <= RESP;
          MEM_ON <= 1'b0;
          MEM_W  <= 1'b0;
          if (win_d) begin
            D_DONE  <= 1'b1;
            D_ERR   <= err;
            D_RDATA <= (err || is_wr) ? '0 : MEM_DOUT;
          end else begin
            IF_DONE  <= 1'b1;
            IF_ERR   <= err;
            IF_RDATA <= err ? '0 : MEM_DOUT;
          end
        end
        RESP: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, directed scenarios and
// randomized two-requester traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        IF_REQ;
  logic [15:0] IF_ADDR;
  logic        IF_DONE;
  logic [15:0] IF_RDATA;
  logic        IF_ERR;
  logic        D_REQ;
  logic        D_WE;
  logic [15:0] D_ADDR;
  logic [15:0] D_WDATA;
  logic        D_DONE;
  logic [15:0] D_RDATA;
  logic        D_ERR;
  logic        MEM_ON;
  logic        MEM_W;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_DIN;
  logic        BUSY;

  logic [15:0] mem     [16];
  logic [15:0] ref_mem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  int n_cmp = 0;
  int n_bad = 0;
  int m_starve = 0;
  logic [15:0] exp_ifr = '0;
  logic [15:0] exp_dr  = '0;

  wire [15:0] MEM_DOUT =
    (MEM_ON && !MEM_W) ? mem[MEM_ADDR[3:0]] : 16'hzzzz;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR),
    .IF_DONE(IF_DONE), .IF_RDATA(IF_RDATA),
    .IF_ERR(IF_ERR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_DONE(D_DONE),
    .D_RDATA(D_RDATA), .D_ERR(D_ERR),
    .MEM_ON(MEM_ON), .MEM_W(MEM_W),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: write commits at the edge ending an ON&W cycle
  always @(posedge CLK) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (MEM_ON && MEM_W && MEM_ADDR < 16'd16)
      mem[MEM_ADDR[3:0]] <= MEM_DIN;
  end

  task automatic preload(input int a, input logic [15:0] v);
    pl_en = 1'b1;
    pl_addr = 4'(a);
    pl_data = v;
    ref_mem[a] = v;
    @(posedge CLK); #1;
    pl_en = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) == 0)
      return 16'(16 + $urandom_range(0, 65519));
    return 16'($urandom_range(0, 15));
  endfunction

  task automatic do_req(
    input  bit          is_d,
    input  bit          we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output int          lat,
    output logic [15:0] rdata,
    output logic        err,
    output int          on_cyc,
    output int          w_cyc,
    output bit          other
  );
    if (is_d) begin
      D_REQ = 1'b1; D_WE = we;
      D_ADDR = addr; D_WDATA = wdata;
    end else begin
      IF_REQ = 1'b1; IF_ADDR = addr;
    end
    lat = 0; on_cyc = 0; w_cyc = 0; other = 0;
    rdata = 'x; err = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      if (MEM_ON) on_cyc++;
      if (MEM_W) w_cyc++;
      if (is_d ? IF_DONE : D_DONE) other = 1;
      if (is_d ? D_DONE : IF_DONE) begin
        lat = k;
        rdata = is_d ? D_RDATA : IF_RDATA;
        err = is_d ? D_ERR : IF_ERR;
        break;
      end
    end
    IF_REQ = 1'b0;
    D_REQ = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({IF_DONE, IF_ERR, D_DONE, D_ERR,
         MEM_ON, MEM_W, BUSY} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got=%b want=0",
        {IF_DONE, IF_ERR, D_DONE, D_ERR,
         MEM_ON, MEM_W, BUSY});
    end
    n_cmp++;
    if ({IF_RDATA, D_RDATA, MEM_ADDR, MEM_DIN} !== 64'b0) begin
      n_bad++;
      $display("FAIL reset_data got=%h want=0",
        {IF_RDATA, D_RDATA, MEM_ADDR, MEM_DIN});
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_fetch();
    int lat, onc, wc;
    logic [15:0] rd;
    logic er;
    bit oth;
    preload(0, 16'h100B);
    do_req(0, 0, 16'h0000, 16'h0, lat, rd, er, onc, wc, oth);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL fetch_latency got=%0d want=2", lat);
    end
    n_cmp++;
    if (rd !== 16'h100B || er !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_data got=%h/%b want=100b/0", rd, er);
    end
    n_cmp++;
    if (onc != 1 || wc != 0 || oth) begin
      n_bad++;
      $display("FAIL fetch_mem got on=%0d w=%0d oth=%0d want 1/0/0",
        onc, wc, oth);
    end
    n_cmp++;
    if (IF_RDATA !== 16'h100B || IF_DONE !== 1'b0
        || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_hold got=%h/%b/%b want=100b/0/0",
        IF_RDATA, IF_DONE, BUSY);
    end
  endtask

  task automatic test_store_load();
    int lat, onc, wc;
    logic [15:0] rd;
    logic er;
    bit oth;
    do_req(1, 1, 16'd11, 16'h7FFF, lat, rd, er, onc, wc, oth);
    ref_mem[11] = 16'h7FFF;
    n_cmp++;
    if (lat !== 2 || rd !== 16'h0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL store_resp got lat=%0d rd=%h err=%b want 2/0/0",
        lat, rd, er);
    end
    n_cmp++;
    if (wc != 1 || onc != 1 || mem[11] !== 16'h7FFF) begin
      n_bad++;
      $display("FAIL store_mem got w=%0d on=%0d m=%h want 1/1/7fff",
        wc, onc, mem[11]);
    end
    do_req(1, 0, 16'd11, 16'h0, lat, rd, er, onc, wc, oth);
    n_cmp++;
    if (lat !== 2 || rd !== 16'h7FFF || er !== 1'b0 || wc != 0) begin
      n_bad++;
      $display("FAIL load_resp got lat=%0d rd=%h err=%b w=%0d want 2/7fff/0/0",
        lat, rd, er, wc);
    end
  endtask

  task automatic test_starvation();
    int got = 0;
    bit want_if;
    IF_ADDR = 16'd3;
    D_ADDR = 16'd5;
    D_WE = 1'b0;
    IF_REQ = 1'b1;
    D_REQ = 1'b1;
    for (int k = 0; k < 60 && got < 10; k++) begin
      @(posedge CLK); #1;
      if (IF_DONE || D_DONE) begin
        want_if = (got % 5) == 4;
        n_cmp++;
        if (IF_DONE !== want_if || D_DONE !== !want_if) begin
          n_bad++;
          $display("FAIL starve_order grant%0d got if=%b d=%b want if=%b",
            got, IF_DONE, D_DONE, want_if);
        end
        n_cmp++;
        if (want_if ? IF_RDATA !== ref_mem[3]
                    : D_RDATA !== ref_mem[5]) begin
          n_bad++;
          $display("FAIL starve_data grant%0d got %h/%h want %h/%h",
            got, IF_RDATA, D_RDATA, ref_mem[3], ref_mem[5]);
        end
        got++;
        if (got == 10) begin
          IF_REQ = 1'b0;
          D_REQ = 1'b0;
        end
      end
    end
    n_cmp++;
    if (got != 10) begin
      n_bad++;
      $display("FAIL starve_count got=%0d want=10", got);
    end
    IF_REQ = 1'b0;
    D_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_out_of_range();
    int lat, onc, wc, diff;
    logic [15:0] rd;
    logic er;
    bit oth;
    do_req(1, 0, 16'h0010, 16'h0, lat, rd, er, onc, wc, oth);
    n_cmp++;
    if (lat !== 2 || er !== 1'b1 || rd !== 16'h0 || onc != 0) begin
      n_bad++;
      $display("FAIL oor_load got lat=%0d err=%b rd=%h on=%0d want 2/1/0/0",
        lat, er, rd, onc);
    end
    do_req(1, 1, 16'hFFFF, 16'h1234, lat, rd, er, onc, wc, oth);
    n_cmp++;
    if (er !== 1'b1 || onc != 0 || wc != 0) begin
      n_bad++;
      $display("FAIL oor_store got err=%b on=%0d w=%0d want 1/0/0",
        er, onc, wc);
    end
    do_req(0, 0, 16'h8000, 16'h0, lat, rd, er, onc, wc, oth);
    n_cmp++;
    if (lat !== 2 || er !== 1'b1 || rd !== 16'h0 || oth) begin
      n_bad++;
      $display("FAIL oor_fetch got lat=%0d err=%b rd=%h want 2/1/0",
        lat, er, rd);
    end
    diff = 0;
    for (int i = 0; i < 16; i++)
      if (mem[i] !== ref_mem[i]) diff++;
    n_cmp++;
    if (diff != 0) begin
      n_bad++;
      $display("FAIL oor_memory got %0d changed words want 0", diff);
    end
  endtask

  task automatic test_rst_access();
    preload(12, 16'h0000);
    D_REQ = 1'b1; D_WE = 1'b1;
    D_ADDR = 16'd12; D_WDATA = 16'hFFFD;
    @(posedge CLK); #1;
    n_cmp++;
    if (MEM_ON !== 1'b1 || MEM_W !== 1'b1 || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_access got on=%b w=%b busy=%b want 1/1/1",
        MEM_ON, MEM_W, BUSY);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    D_REQ = 1'b0;
    RST = 1'b0;
    n_cmp++;
    if ({D_DONE, D_ERR, IF_DONE, MEM_ON, MEM_W, BUSY} !== 6'b0
        || {D_RDATA, IF_RDATA} !== 32'b0) begin
      n_bad++;
      $display("FAIL rst_outputs got ctl=%b rd=%h/%h want 0",
        {D_DONE, D_ERR, IF_DONE, MEM_ON, MEM_W, BUSY},
        D_RDATA, IF_RDATA);
    end
    n_cmp++;
    if (mem[12] !== 16'hFFFD) begin
      n_bad++;
      $display("FAIL rst_commit got=%h want=fffd", mem[12]);
    end
    ref_mem[12] = 16'hFFFD;
    exp_ifr = '0;
    exp_dr = '0;
    m_starve = 0;
    repeat (2) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (D_DONE !== 1'b0 || BUSY !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_no_done got done=%b busy=%b want 0/0",
          D_DONE, BUSY);
      end
    end
  endtask

  task automatic test_random(input int n, input int pr);
    int free_at = 0;
    int acc = -100;
    bit w_d = 0, w_err = 0, w_wr = 0;
    bit e_ifd, e_dd, e_on, e_busy;
    logic [15:0] w_rd = '0;
    logic [15:0] a;
    for (int k = 0; k < n + 24; k++) begin
      if (k >= free_at && (IF_REQ || D_REQ)) begin
        w_d = D_REQ && !(IF_REQ && m_starve == 4);
        if (w_d && IF_REQ) m_starve++;
        else m_starve = 0;
        a = w_d ? D_ADDR : IF_ADDR;
        w_err = a >= 16'd16;
        w_wr = w_d && D_WE;
        w_rd = (w_err || w_wr) ? 16'h0 : ref_mem[a[3:0]];
        if (w_wr && !w_err) ref_mem[a[3:0]] = D_WDATA;
        acc = k;
        free_at = k + 3;
      end
      @(posedge CLK); #1;
      e_ifd = (acc == k - 1) && !w_d;
      e_dd = (acc == k - 1) && w_d;
      e_on = (acc == k) && !w_err;
      e_busy = (acc == k) || (acc == k - 1);
      if (e_ifd) exp_ifr = w_rd;
      if (e_dd) exp_dr = w_rd;
      n_cmp++;
      if (IF_DONE !== e_ifd || D_DONE !== e_dd
          || IF_ERR !== (e_ifd && w_err)
          || D_ERR !== (e_dd && w_err)) begin
        n_bad++;
        $display("FAIL rand_done cyc%0d got if=%b/%b d=%b/%b want %b/%b %b/%b",
          k, IF_DONE, IF_ERR, D_DONE, D_ERR,
          e_ifd, e_ifd && w_err, e_dd, e_dd && w_err);
      end
      n_cmp++;
      if (IF_RDATA !== exp_ifr || D_RDATA !== exp_dr) begin
        n_bad++;
        $display("FAIL rand_rdata cyc%0d got %h/%h want %h/%h",
          k, IF_RDATA, D_RDATA, exp_ifr, exp_dr);
      end
      n_cmp++;
      if (MEM_ON !== e_on || MEM_W !== (e_on && w_wr)
          || BUSY !== e_busy) begin
        n_bad++;
        $display("FAIL rand_mem cyc%0d got on=%b w=%b busy=%b want %b/%b/%b",
          k, MEM_ON, MEM_W, BUSY, e_on, e_on && w_wr, e_busy);
      end
      if (e_ifd) IF_REQ = 1'b0;
      if (e_dd) D_REQ = 1'b0;
      if (k < n && !IF_REQ && $urandom_range(0, 99) < pr) begin
        IF_REQ = 1'b1;
        IF_ADDR = rand_addr();
      end
      if (k < n && !D_REQ && $urandom_range(0, 99) < pr) begin
        D_REQ = 1'b1;
        D_WE = 1'($urandom_range(0, 1));
        D_ADDR = rand_addr();
        D_WDATA = 16'($urandom());
      end
    end
    n_cmp++;
    if (IF_REQ || D_REQ) begin
      n_bad++;
      $display("FAIL rand_drain got if_req=%b d_req=%b want 0/0",
        IF_REQ, D_REQ);
    end
  endtask

  initial begin
    RST = 1'b1;
    IF_REQ = 1'b0; IF_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0;
    D_ADDR = '0; D_WDATA = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 16; i++)
      preload(i, 16'($urandom()));
    test_reset();
    test_fetch();
    test_store_load();
    test_starvation();
    test_out_of_range();
    test_rst_access();
    test_random(300, 30);
    test_random(300, 90);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
